// File: rtl/core_avl_arbiter.sv
// Two-master / one-slave Avalon arbiter: round-robin command grant with stall lock,
// and a read-ID FIFO that steers pipelined read responses back to their issuer.
module core_avl_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rest,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid,
    output logic                rsp_err
);
    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              rd;
        logic              wr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } cmd_t;

    cmd_t [1:0]                 mcmd;
    cmd_t                       sel;
    logic [1:0]                 req;
    logic                       lock, lock_id, last_grant, rsp_err_q;
    logic                       gnt, gnt_vld, out_en;
    logic                       cmd_rd, cmd_wr, rd_blocked, present, accepted;
    logic [MAX_OUTSTANDING-1:0] id_mem;
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       fifo_full, fifo_nonempty, push, pop, head_id;

    assign mcmd[0] = {m0_address, m0_read, m0_write, m0_writedata, m0_byteenable};
    assign mcmd[1] = {m1_address, m1_read, m1_write, m1_writedata, m1_byteenable};
    assign req     = {mcmd[1].rd | mcmd[1].wr, mcmd[0].rd | mcmd[0].wr};

    always_comb begin
        gnt     = 1'b0;
        gnt_vld = 1'b0;
        if (lock) begin
            gnt     = lock_id;
            gnt_vld = 1'b1;
        end else if (&req) begin
            gnt     = ~last_grant;
            gnt_vld = 1'b1;
        end else if (|req) begin
            gnt     = req[1];
            gnt_vld = 1'b1;
        end
    end

    // Read wins over write for the illegal read+write combination.
    assign sel        = mcmd[gnt];
    assign out_en     = gnt_vld & ~rest;
    assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
    assign cmd_rd     = out_en & sel.rd;
    assign cmd_wr     = out_en & sel.wr & ~sel.rd;
    assign rd_blocked = cmd_rd & fifo_full;
    assign present    = s_read | s_write;
    assign accepted   = present & ~s_waitrequest;

    assign s_read       = cmd_rd & ~fifo_full;
    assign s_write      = cmd_wr;
    assign s_address    = out_en ? sel.addr  : '0;
    assign s_writedata  = out_en ? sel.wdata : '0;
    assign s_byteenable = out_en ? sel.be    : '0;

    assign m0_waitrequest = ~(accepted & ~gnt);
    assign m1_waitrequest = ~(accepted & gnt);

    // Lock simply remembers "the granted master stalled this cycle"; acceptance clears it.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            lock       <= 1'b0;
            lock_id    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            lock    <= (present & s_waitrequest) | rd_blocked;
            lock_id <= gnt;
            if (accepted)
                last_grant <= gnt;
        end
    end

    assign fifo_nonempty = (count != '0);
    assign push          = accepted & s_read;
    assign pop           = s_readdatavalid & fifo_nonempty;
    assign head_id       = id_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            id_mem[wr_ptr] <= gnt;
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (s_readdatavalid & ~fifo_nonempty)
                rsp_err_q <= 1'b1;
        end
    end

    assign m0_readdatavalid = pop & ~head_id;
    assign m1_readdatavalid = pop & head_id;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign rsp_err          = rsp_err_q;

endmodule
